// File: rtl/xvec_mul_div_iter.sv
// Iterative multiply/divide for LANES independent XLEN-bit lanes: one shift-add or
// restoring-subtract step per cycle, then one setup cycle for sign fix and special cases.
module xvec_mul_div_iter #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_in_1_signed,
  input  logic                  req_in_2_signed,
  input  logic [1:0]            req_op,
  input  logic [1:0]            req_out_sel,
  input  logic [LANES*XLEN-1:0] req_in_1,
  input  logic [LANES*XLEN-1:0] req_in_2,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LANES*XLEN-1:0] resp_result,
  output logic [1:0]            state_dbg
);

  localparam int DW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // req_ready is high only in IDLE, resp_valid only in DONE, and both are registered.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    SETUP   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             op_div;
  logic             op_rem;
  logic             sel_hi;
  logic             sel_rem;

  logic [DW-1:0]    a_q     [LANES];
  logic [DW-1:0]    b_q     [LANES];
  logic [DW-1:0]    res_q   [LANES];
  logic [XLEN-1:0]  in1_q   [LANES];
  logic             neg_q   [LANES];
  logic             zero_q  [LANES];
  logic             ovf_q   [LANES];

  logic [XLEN-1:0]  op1     [LANES];
  logic [XLEN-1:0]  op2     [LANES];
  logic [XLEN-1:0]  abs1    [LANES];
  logic [XLEN-1:0]  abs2    [LANES];
  logic             sign1   [LANES];
  logic             sign2   [LANES];

  logic [DW-1:0]    step_a  [LANES];
  logic [DW-1:0]    step_b  [LANES];
  logic [DW-1:0]    step_res[LANES];
  logic [DW-1:0]    sel_v   [LANES];
  logic [XLEN-1:0]  fin     [LANES];
  logic [LANES*XLEN-1:0] fin_bus;

  logic req_div;
  logic req_rem;
  logic is_mul;

  assign req_div   = (req_op == 2'd1);
  assign req_rem   = (req_op == 2'd2);
  assign is_mul    = !op_div && !op_rem;
  assign state_dbg = state;

  always_comb begin : capture_decode
    for (int i = 0; i < LANES; i++) begin
      op1[i]   = req_in_1[i*XLEN +: XLEN];
      op2[i]   = req_in_2[i*XLEN +: XLEN];
      sign1[i] = req_in_1_signed & op1[i][XLEN-1];
      sign2[i] = req_in_2_signed & op2[i][XLEN-1];
      abs1[i]  = sign1[i] ? -op1[i] : op1[i];
      abs2[i]  = sign2[i] ? -op2[i] : op2[i];
    end
  end

  always_comb begin : datapath
    fin_bus = '0;
    for (int i = 0; i < LANES; i++) begin
      step_a[i]   = a_q[i];
      step_res[i] = res_q[i];
      step_b[i]   = b_q[i] >> 1;
      if (is_mul) begin
        if (a_q[i][counter]) step_res[i] = res_q[i] + b_q[i];
      end else if (a_q[i] >= b_q[i]) begin
        step_a[i]   = a_q[i] - b_q[i];
        step_res[i] = res_q[i] | (DW'(1) << counter);
      end

      sel_v[i] = sel_rem ? a_q[i] : res_q[i];
      if (neg_q[i]) sel_v[i] = -sel_v[i];
      fin[i] = sel_hi ? sel_v[i][DW-1:XLEN] : sel_v[i][XLEN-1:0];

      // RISC-V mandated results for x/0 and MIN/-1 take precedence over the datapath
      if (zero_q[i]) begin
        if (op_div)      fin[i] = '1;
        else if (op_rem) fin[i] = in1_q[i];
      end else if (ovf_q[i]) begin
        if (op_div)      fin[i] = in1_q[i];
        else if (op_rem) fin[i] = '0;
      end
      fin_bus[i*XLEN +: XLEN] = fin[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      counter     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            for (int i = 0; i < LANES; i++) begin
              a_q[i]    <= {{XLEN{1'b0}}, abs1[i]};
              b_q[i]    <= {1'b0, abs2[i], {(XLEN-1){1'b0}}};
              res_q[i]  <= '0;
              in1_q[i]  <= op1[i];
              neg_q[i]  <= req_rem ? sign1[i] : (sign1[i] ^ sign2[i]);
              zero_q[i] <= (op2[i] == '0);
              ovf_q[i]  <= req_in_1_signed && req_in_2_signed &&
                           (op1[i] == MIN_NEG) && (&op2[i]);
            end
            op_div    <= req_div;
            op_rem    <= req_rem;
            sel_hi    <= (req_out_sel == 2'd1);
            sel_rem   <= (req_out_sel == 2'd2);
            counter   <= CNT_W'(XLEN - 1);
            req_ready <= 1'b0;
            state     <= COMPUTE;
          end
        end
        COMPUTE: begin
          for (int i = 0; i < LANES; i++) begin
            a_q[i]   <= step_a[i];
            b_q[i]   <= step_b[i];
            res_q[i] <= step_res[i];
          end
          counter <= counter - CNT_W'(1);
          if (counter == '0) state <= SETUP;
        end
        SETUP: begin
          resp_result <= fin_bus;
          resp_valid  <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
